// File: rtl/dmem_lat_if.sv
// Core-side data memory bus: one read and one write request per cycle, registered response.
interface dmem_lat_if #(
    parameter int unsigned DWIDTH = 32
);
    logic                i_ren;
    logic                i_wen;
    logic [DWIDTH/8-1:0] i_wstrb;
    logic [31:0]         i_addr;
    logic [DWIDTH-1:0]   i_wdata;
    logic                o_rvd;
    logic [DWIDTH-1:0]   o_rdata;
    logic                o_err;

    modport master (
        output i_ren, i_wen, i_wstrb, i_addr, i_wdata,
        input  o_rvd, o_rdata, o_err
    );

    modport slave (
        input  i_ren, i_wen, i_wstrb, i_addr, i_wdata,
        output o_rvd, o_rdata, o_err
    );
endinterface

// File: rtl/dmem_lat.sv
// Data memory with configurable width, depth and read latency, byte strobes and misalignment errors.
// Reads sample the array on the request edge and ride an RLAT-deep {valid, err, data} pipeline.
module dmem_lat #(
    parameter int unsigned DWIDTH   = 32,
    parameter int unsigned DEPTH    = 8192,
    parameter int unsigned RLAT     = 2,
    parameter string       INITFILE = ""
) (
    input  logic      clk,
    input  logic      rst,
    dmem_lat_if.slave bus
);
    localparam int unsigned NBYTES = DWIDTH / 8;
    localparam int unsigned OFFW   = $clog2(NBYTES);
    localparam int unsigned IDXW   = $clog2(DEPTH);

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [IDXW-1:0]   word_idx;
    logic              misaligned;
    logic              unused_addr;

    logic [RLAT-1:0]   vld_d, vld_q;
    logic [RLAT-1:0]   err_d, err_q;
    logic [DWIDTH-1:0] dat_d [RLAT];
    logic [DWIDTH-1:0] dat_q [RLAT];
    logic              werr_d, werr_q;

    assign word_idx    = bus.i_addr[IDXW+OFFW-1:OFFW];
    assign misaligned  = |bus.i_addr[OFFW-1:0];
    assign unused_addr = ^bus.i_addr[31:IDXW+OFFW];

    // Writes land at the request edge; a same-edge read has already sampled the old word.
    always_ff @(posedge clk) begin
        if (!rst && bus.i_wen && !misaligned) begin
            for (int unsigned b = 0; b < NBYTES; b++) begin
                if (bus.i_wstrb[b]) mem_q[word_idx][8*b +: 8] <= bus.i_wdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        vld_d = '0;
        err_d = '0;
        dat_d = dat_q;

        vld_d[0] = bus.i_ren;
        err_d[0] = bus.i_ren & misaligned;
        if (!bus.i_ren) begin
            dat_d[0] = dat_q[0];
        end else if (misaligned) begin
            dat_d[0] = '0;
        end else begin
            dat_d[0] = mem_q[word_idx];
        end

        // Data only advances with a valid, so the last stage holds o_rdata between responses.
        for (int unsigned s = 1; s < RLAT; s++) begin
            vld_d[s] = vld_q[s-1];
            err_d[s] = err_q[s-1];
            dat_d[s] = vld_q[s-1] ? dat_q[s-1] : dat_q[s];
        end

        werr_d = bus.i_wen & misaligned;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            err_q  <= '0;
            werr_q <= 1'b0;
            for (int unsigned s = 0; s < RLAT; s++) begin
                dat_q[s] <= '0;
            end
        end else begin
            vld_q  <= vld_d;
            err_q  <= err_d;
            werr_q <= werr_d;
            for (int unsigned s = 0; s < RLAT; s++) begin
                dat_q[s] <= dat_d[s];
            end
        end
    end

    assign bus.o_rvd   = vld_q[RLAT-1];
    assign bus.o_err   = err_q[RLAT-1] | werr_q;
    assign bus.o_rdata = dat_q[RLAT-1];
endmodule

// File: tb/tb_dmem_lat.sv
// Bench for dmem_lat: two instances (RLAT 2 and 4) share one stimulus stream and are checked
// every cycle against a byte-array reference with per-cycle scheduled responses.
module tb_dmem_lat;
    localparam int unsigned DW     = 32;
    localparam int unsigned DEPTH  = 8192;
    localparam int unsigned WBYTES = DEPTH * 4;
    localparam int          NDUT   = 2;
    localparam int          LAT_A  = 2;
    localparam int          LAT_B  = 4;
    localparam int          NVEC   = 6;

    typedef struct packed {
        logic          rvd;
        logic          err;
        logic [DW-1:0] data;
    } resp_t;

    typedef struct {
        string       name;
        logic [31:0] a1;
        logic [31:0] d1;
        logic [3:0]  s1;
        logic [31:0] a2;
        logic [31:0] d2;
        logic [3:0]  s2;
        logic [31:0] ra;
        logic [31:0] exp_data;
        logic        exp_err;
        logic        exp_werr;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_lat_if #(.DWIDTH(DW)) bus_a ();
    dmem_lat_if #(.DWIDTH(DW)) bus_b ();

    assign bus_b.i_ren   = bus_a.i_ren;
    assign bus_b.i_wen   = bus_a.i_wen;
    assign bus_b.i_wstrb = bus_a.i_wstrb;
    assign bus_b.i_addr  = bus_a.i_addr;
    assign bus_b.i_wdata = bus_a.i_wdata;

    dmem_lat #(.DWIDTH(DW), .DEPTH(DEPTH), .RLAT(LAT_A), .INITFILE("")) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    dmem_lat #(.DWIDTH(DW), .DEPTH(DEPTH), .RLAT(LAT_B), .INITFILE("")) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    logic [NDUT-1:0] mon_rvd;
    logic [NDUT-1:0] mon_err;
    logic [DW-1:0]   mon_data [NDUT];
    assign mon_rvd     = {bus_b.o_rvd, bus_a.o_rvd};
    assign mon_err     = {bus_b.o_err, bus_a.o_err};
    assign mon_data[0] = bus_a.o_rdata;
    assign mon_data[1] = bus_b.o_rdata;

    // Reference: byte array, responses scheduled by the edge after which they must be visible.
    logic [7:0]    ref_mem [int unsigned];
    resp_t         sched [int];
    resp_t         hist [int];
    logic [DW-1:0] last_data [NDUT];
    int            edge_n = 0;
    int            checks = 0;
    int            errors = 0;
    vec_t          vecs [NVEC];

    function automatic int lat_of(input int k);
        return (k == 0) ? LAT_A : LAT_B;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        int unsigned base;
        logic [31:0] v;
        base = (a % WBYTES) & ~32'd3;
        for (int b = 0; b < 4; b++) begin
            v[8*b +: 8] = ref_mem.exists(base + b) ? ref_mem[base + b] : 8'hxx;
        end
        return v;
    endfunction

    task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int unsigned base;
        base = (a % WBYTES) & ~32'd3;
        for (int b = 0; b < 4; b++) begin
            if (s[b]) ref_mem[base + b] = d[8*b +: 8];
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp_v, edge_n);
        end
    endtask

    task automatic model_edge(input logic r, input logic w, input logic [3:0] s,
                              input logic [31:0] a, input logic [31:0] d, input logic rs);
        resp_t       t;
        logic [31:0] rd;
        int          key;
        if (rs) begin
            for (int k = 0; k < NDUT; k++) begin
                for (int e = edge_n; e <= edge_n + 8; e++) begin
                    if (sched.exists(e*2 + k)) sched.delete(e*2 + k);
                end
                last_data[k] = '0;
            end
            return;
        end
        if (r) begin
            rd = (a[1:0] != 2'b00) ? 32'h0 : ref_read(a);
            for (int k = 0; k < NDUT; k++) begin
                key = (edge_n + lat_of(k) - 1)*2 + k;
                t = '0;
                if (sched.exists(key)) t = sched[key];
                t.rvd  = 1'b1;
                t.err  = t.err | (a[1:0] != 2'b00);
                t.data = rd;
                sched[key] = t;
            end
        end
        if (w) begin
            if (a[1:0] != 2'b00) begin
                for (int k = 0; k < NDUT; k++) begin
                    key = edge_n*2 + k;
                    t = '0;
                    if (sched.exists(key)) t = sched[key];
                    t.err = 1'b1;
                    sched[key] = t;
                end
            end else begin
                ref_write(a, d, s);
            end
        end
    endtask

    task automatic do_cycle(input logic r, input logic w, input logic [3:0] s,
                            input logic [31:0] a, input logic [31:0] d, input logic rs);
        resp_t exp_r;
        resp_t act;
        int    key;
        bus_a.i_ren   = r;
        bus_a.i_wen   = w;
        bus_a.i_wstrb = s;
        bus_a.i_addr  = a;
        bus_a.i_wdata = d;
        rst           = rs;
        edge_n++;
        model_edge(r, w, s, a, d, rs);
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            key   = edge_n*2 + k;
            exp_r = '0;
            if (sched.exists(key)) begin
                exp_r = sched[key];
                sched.delete(key);
            end
            if (exp_r.rvd) last_data[k] = exp_r.data;
            act.rvd  = mon_rvd[k];
            act.err  = mon_err[k];
            act.data = mon_data[k];
            hist[key] = act;
            chk($sformatf("rvd[dut%0d]", k), {31'b0, act.rvd}, {31'b0, exp_r.rvd});
            chk($sformatf("err[dut%0d]", k), {31'b0, act.err}, {31'b0, exp_r.err});
            chk($sformatf("rdata[dut%0d]", k), act.data, last_data[k]);
        end
    endtask

    task automatic idle();
        do_cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    endtask

    function automatic resp_t hist_at(input int e, input int k);
        if (hist.exists(e*2 + k)) return hist[e*2 + k];
        return '0;
    endfunction

    initial begin
        int e0;
        resp_t h;

        vecs[0] = '{"wr_rd",     32'h100,  32'hDEADBEEF, 4'hF, 32'h100, 32'h0,        4'h0,
                    32'h100, 32'hDEADBEEF, 1'b0, 1'b0};
        vecs[1] = '{"strobe",    32'h40,   32'h11223344, 4'hF, 32'h40,  32'hAABBCCDD, 4'h5,
                    32'h40,  32'h11BB33DD, 1'b0, 1'b0};
        vecs[2] = '{"misal_rd",  32'h104,  32'h12345678, 4'hF, 32'h104, 32'hFFFFFFFF, 4'h0,
                    32'h102, 32'h0,        1'b1, 1'b0};
        vecs[3] = '{"misal_wr",  32'h200,  32'hCAFE0000, 4'hF, 32'h201, 32'h7,        4'hF,
                    32'h200, 32'hCAFE0000, 1'b0, 1'b1};
        vecs[4] = '{"alias",     32'h8000, 32'hA5A5A5A5, 4'hF, 32'h4,   32'h1,        4'hF,
                    32'h0,   32'hA5A5A5A5, 1'b0, 1'b0};
        vecs[5] = '{"strobe_hi", 32'h3C,   32'hFFFFFFFF, 4'hF, 32'h3C,  32'h0,        4'hA,
                    32'h3C,  32'h00FF00FF, 1'b0, 1'b0};

        for (int k = 0; k < NDUT; k++) last_data[k] = '0;

        repeat (3) do_cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
        chk("reset_rvd", {31'b0, bus_a.o_rvd}, 32'h0);
        chk("reset_rdata", bus_a.o_rdata, 32'h0);

        for (int i = 0; i < NVEC; i++) begin
            int ew;
            int er;
            do_cycle(1'b0, 1'b1, vecs[i].s1, vecs[i].a1, vecs[i].d1, 1'b0);
            do_cycle(1'b0, 1'b1, vecs[i].s2, vecs[i].a2, vecs[i].d2, 1'b0);
            ew = edge_n;
            do_cycle(1'b1, 1'b0, 4'h0, vecs[i].ra, 32'h0, 1'b0);
            er = edge_n;
            repeat (LAT_B) idle();
            h = hist_at(ew, 0);
            chk({vecs[i].name, "_werr"}, {31'b0, h.err}, {31'b0, vecs[i].exp_werr});
            for (int k = 0; k < NDUT; k++) begin
                h = hist_at(er + lat_of(k) - 2, k);
                chk($sformatf("%s_early[dut%0d]", vecs[i].name, k), {31'b0, h.rvd}, 32'h0);
                h = hist_at(er + lat_of(k) - 1, k);
                chk($sformatf("%s_rvd[dut%0d]", vecs[i].name, k), {31'b0, h.rvd}, 32'h1);
                chk($sformatf("%s_err[dut%0d]", vecs[i].name, k), {31'b0, h.err},
                    {31'b0, vecs[i].exp_err});
                chk($sformatf("%s_data[dut%0d]", vecs[i].name, k), h.data, vecs[i].exp_data);
            end
        end

        // Read-first collision.
        do_cycle(1'b0, 1'b1, 4'hF, 32'h80, 32'h5, 1'b0);
        do_cycle(1'b1, 1'b1, 4'hF, 32'h80, 32'h9, 1'b0);
        e0 = edge_n;
        do_cycle(1'b1, 1'b0, 4'h0, 32'h80, 32'h0, 1'b0);
        repeat (LAT_B) idle();
        for (int k = 0; k < NDUT; k++) begin
            h = hist_at(e0 + lat_of(k) - 1, k);
            chk($sformatf("collide_old[dut%0d]", k), h.data, 32'h5);
            h = hist_at(e0 + lat_of(k), k);
            chk($sformatf("collide_new[dut%0d]", k), h.data, 32'h9);
        end

        // Back-to-back reads of words preloaded with their index.
        for (int i = 0; i < 8; i++) do_cycle(1'b0, 1'b1, 4'hF, 32'(i*4), 32'(i), 1'b0);
        e0 = edge_n + 1;
        for (int i = 0; i < 8; i++) do_cycle(1'b1, 1'b0, 4'h0, 32'(i*4), 32'h0, 1'b0);
        repeat (LAT_B + 1) idle();
        for (int k = 0; k < NDUT; k++) begin
            h = hist_at(e0 + lat_of(k) - 2, k);
            chk($sformatf("burst_pre[dut%0d]", k), {31'b0, h.rvd}, 32'h0);
            for (int i = 0; i < 8; i++) begin
                h = hist_at(e0 + lat_of(k) - 1 + i, k);
                chk($sformatf("burst_rvd%0d[dut%0d]", i, k), {31'b0, h.rvd}, 32'h1);
                chk($sformatf("burst_data%0d[dut%0d]", i, k), h.data, 32'(i));
            end
            h = hist_at(e0 + lat_of(k) + 7, k);
            chk($sformatf("burst_post[dut%0d]", k), {31'b0, h.rvd}, 32'h0);
        end

        // Reset with reads in flight; a write presented during reset must be dropped.
        e0 = edge_n + 1;
        do_cycle(1'b1, 1'b0, 4'h0, 32'h4, 32'h0, 1'b0);
        do_cycle(1'b1, 1'b0, 4'h0, 32'h4, 32'h0, 1'b0);
        do_cycle(1'b1, 1'b1, 4'hF, 32'h4, 32'hBAD, 1'b1);
        repeat (LAT_B + 2) idle();
        for (int k = 0; k < NDUT; k++) begin
            for (int e = e0 + 2; e <= edge_n; e++) begin
                h = hist_at(e, k);
                chk($sformatf("flush_rvd_e%0d[dut%0d]", e - e0, k), {31'b0, h.rvd}, 32'h0);
            end
        end
        e0 = edge_n + 1;
        do_cycle(1'b1, 1'b0, 4'h0, 32'h4, 32'h0, 1'b0);
        repeat (LAT_B) idle();
        for (int k = 0; k < NDUT; k++) begin
            h = hist_at(e0 + lat_of(k) - 1, k);
            chk($sformatf("kept_after_rst[dut%0d]", k), h.data, 32'h1);
        end

        // Randomised traffic over 16 initialised words with aliased upper bits.
        for (int i = 8; i < 16; i++) do_cycle(1'b0, 1'b1, 4'hF, 32'(i*4), $urandom, 1'b0);
        for (int n = 0; n < 2000; n++) begin
            logic [31:0] a;
            a = ($urandom & 32'hFFFF_8000) | (32'($urandom_range(0, 15)) << 2);
            if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
            do_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     4'($urandom_range(0, 15)), a, $urandom, ($urandom_range(0, 149) == 0));
        end
        repeat (LAT_B + 1) idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
